// File: rtl/mem_fill_pkg.sv
// rtl/mem_fill_pkg.sv - shared widths and state encoding for the line fill controller
package mem_fill_pkg;

  localparam int LINE_W = 256;
  localparam int BE_W   = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WB_SETUP,
    WB_COMMIT,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_fill_ctrl.sv
// rtl/mem_fill_ctrl.sv - cache-side victim writeback and line fill sequencer
module mem_fill_ctrl
  import mem_fill_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [BE_W-1:0]   req_wb_be,
  input  logic [LINE_W-1:0] req_wb_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [LINE_W-1:0] resp_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic [BE_W-1:0]   mem_be,
  output logic [LINE_W-1:0] mem_wd,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [LINE_W-1:0] mem_rd,
  input  logic              mem_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic                fill_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [BE_W-1:0]     wb_be_q;
  logic [LINE_W-1:0]   wb_data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                resp_err_q;
  logic [LINE_W-1:0]   resp_data_q;

  logic accept;
  logic range_bad;
  logic timeout_hit;

  assign accept      = req_valid && (state == IDLE);
  assign range_bad   = (req_wb   && (req_wb_addr >= ADDR_W'(ENTRIES))) ||
                       (req_fill && (req_addr    >= ADDR_W'(ENTRIES)));
  // The last allowed wait cycle is the one where the counter would step to TIMEOUT.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and memory strobe generation from the latched request.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_a      = '0;
    mem_be     = '0;
    mem_wd     = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (range_bad)     state_nxt = RESP;
          else if (req_wb)   state_nxt = WB_SETUP;
          else if (req_fill) state_nxt = RD_ISSUE;
          else               state_nxt = RESP;
        end
      end
      WB_SETUP: begin
        mem_a     = wb_addr_q;
        state_nxt = WB_COMMIT;
      end
      WB_COMMIT: begin
        mem_a     = wb_addr_q;
        mem_be    = wb_be_q;
        mem_wd    = wb_data_q;
        mem_write = 1'b1;
        state_nxt = fill_q ? RD_ISSUE : RESP;
      end
      RD_ISSUE: begin
        mem_a     = addr_q;
        mem_read  = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_valid || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture request fields on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q    <= 1'b0;
      addr_q    <= '0;
      wb_addr_q <= '0;
      wb_be_q   <= '0;
      wb_data_q <= '0;
    end else if (accept) begin
      fill_q    <= req_fill;
      addr_q    <= req_addr;
      wb_addr_q <= req_wb_addr;
      wb_be_q   <= req_wb_be;
      wb_data_q <= req_wb_data;
    end
  end

  // Wait counter: cleared as the read is issued, counts RD_WAIT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (state_nxt == RD_ISSUE) cnt_q <= '0;
    else if (state == RD_WAIT)      cnt_q <= cnt_q + CNT_W'(1);
  end

  // Response payload: range errors flagged at accept, fill data or timeout from RD_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else if (accept) begin
      resp_err_q  <= range_bad;
      resp_data_q <= '0;
    end else if (state == RD_WAIT) begin
      if (mem_valid)        resp_data_q <= mem_rd;
      else if (timeout_hit) resp_err_q  <= 1'b1;
    end
  end

  assign resp_err  = resp_err_q;
  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb/tb_mem_fill_ctrl.sv - directed self-checking bench for mem_fill_ctrl
module tb_mem_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_fill, req_wb;
  logic [31:0]  req_addr, req_wb_addr, req_wb_be;
  logic [255:0] req_wb_data;
  logic         resp_valid, resp_err;
  logic [255:0] resp_data;
  logic [31:0]  mem_a, mem_be;
  logic [255:0] mem_wd, mem_rd;
  logic         mem_write, mem_read, mem_valid;

  int total = 0;
  int bad   = 0;

  mem_fill_ctrl #(.ENTRIES(256), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fill(req_fill), .req_addr(req_addr),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_be(req_wb_be), .req_wb_data(req_wb_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rd(mem_rd), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // Memory stub: byte-enabled write, two-cycle read latency, mute/stray controls.
  logic [255:0] mem [256];
  logic         p1_v = 1'b0, p2_v = 1'b0;
  logic [7:0]   p1_a = '0;
  logic [255:0] p2_d = '0;
  logic         mute = 1'b0, stray = 1'b0;
  logic         pl_en = 1'b0;
  logic [7:0]   pl_a = '0;
  logic [255:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (mem_write)
      for (int i = 0; i < 32; i++)
        if (mem_be[i]) mem[mem_a[7:0]][i*8 +: 8] <= mem_wd[i*8 +: 8];
    p1_v <= mem_read;
    p1_a <= mem_a[7:0];
    p2_v <= p1_v;
    p2_d <= mem[p1_a];
  end

  assign mem_rd    = p2_d;
  assign mem_valid = (p2_v & ~mute) | stray;

  // Per-request observation log, indexed by cycle after the accept edge.
  logic [31:0]  a_log  [16];
  logic         wr_log [16];
  logic         rd_log [16];
  int           resp_cyc;
  logic [255:0] resp_d;
  logic         resp_e;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_9  = {8{32'h1234_5678}};
  localparam logic [255:0] PAT_WB = {8{32'hCAFE_0F0F}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [255:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  // Present one request; returns sampled in cycle 1 with req_valid dropped.
  task automatic send(input logic wb, input logic fill, input logic [31:0] addr,
                      input logic [31:0] wa, input logic [31:0] be, input logic [255:0] wd);
    req_wb = wb; req_fill = fill; req_addr = addr;
    req_wb_addr = wa; req_wb_be = be; req_wb_data = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic watch(input int ncyc);
    resp_cyc = -1; resp_d = '0; resp_e = 1'b0;
    for (int c = 0; c < 16; c++) begin
      a_log[c] = '0; wr_log[c] = 1'b0; rd_log[c] = 1'b0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      a_log[c] = mem_a; wr_log[c] = mem_write; rd_log[c] = mem_read;
      if (resp_valid && resp_cyc < 0) begin
        resp_cyc = c; resp_d = resp_data; resp_e = resp_err;
      end
      if (c < ncyc) step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b%b exp=00", resp_valid, resp_err); end
    total++; if (resp_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", resp_data); end
    total++; if ({mem_read, mem_write} !== 2'b00 || mem_a !== 32'd0 || mem_be !== 32'd0 || mem_wd !== '0) begin
      bad++; $display("FAIL reset_mem got rd=%b wr=%b a=%h exp all 0", mem_read, mem_write, mem_a);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_only();
    int nrd;
    send(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, '0);
    watch(6);
    nrd = 0;
    for (int c = 1; c <= 6; c++) nrd += int'(rd_log[c]);
    total++; if (rd_log[1] !== 1'b1 || a_log[1] !== 32'd3) begin bad++; $display("FAIL fill_issue got rd=%b a=%0d exp rd=1 a=3", rd_log[1], a_log[1]); end
    total++; if (nrd != 1) begin bad++; $display("FAIL fill_read_count got=%0d exp=1", nrd); end
    total++; if (resp_cyc != 4) begin bad++; $display("FAIL fill_latency got=%0d exp=4", resp_cyc); end
    total++; if (resp_d !== PAT_A5 || resp_e !== 1'b0) begin bad++; $display("FAIL fill_data got=%h err=%b exp=%h err=0", resp_d, resp_e, PAT_A5); end
    step();
  endtask

  task automatic test_wb_fill();
    int nwr;
    send(1'b1, 1'b1, 32'd5, 32'd5, 32'h0000_000F, {224'd0, 32'hDEAD_BEEF});
    watch(8);
    nwr = 0;
    for (int c = 1; c <= 8; c++) nwr += int'(wr_log[c]);
    total++; if (wr_log[2] !== 1'b1 || nwr != 1) begin bad++; $display("FAIL wbf_write got c2=%b n=%0d exp c2=1 n=1", wr_log[2], nwr); end
    total++; if (a_log[1] !== 32'd5 || a_log[2] !== 32'd5) begin bad++; $display("FAIL wbf_addr got %0d,%0d exp 5,5", a_log[1], a_log[2]); end
    total++; if (rd_log[3] !== 1'b1) begin bad++; $display("FAIL wbf_read_cycle got=%b exp=1", rd_log[3]); end
    total++; if (resp_cyc != 6) begin bad++; $display("FAIL wbf_latency got=%0d exp=6", resp_cyc); end
    total++; if (resp_d !== {224'd0, 32'hDEAD_BEEF} || resp_e !== 1'b0) begin bad++; $display("FAIL wbf_data got=%h err=%b", resp_d, resp_e); end
    step();
  endtask

  task automatic test_wb_only();
    send(1'b1, 1'b0, 32'd0, 32'd7, 32'hFFFF_FFFF, PAT_WB);
    watch(5);
    total++; if (resp_cyc != 3 || resp_e !== 1'b0) begin bad++; $display("FAIL wbo_latency got=%0d err=%b exp=3 err=0", resp_cyc, resp_e); end
    total++; if (rd_log[1] | rd_log[2] | rd_log[3] | rd_log[4] | rd_log[5]) begin bad++; $display("FAIL wbo_no_read got a read exp none"); end
    total++; if (mem[7] !== PAT_WB) begin bad++; $display("FAIL wbo_line got=%h exp=%h", mem[7], PAT_WB); end
    step();
  endtask

  task automatic test_range_and_noop();
    logic any;
    send(1'b0, 1'b1, 32'd256, 32'd0, 32'd0, '0);
    watch(4);
    any = 1'b0;
    for (int c = 1; c <= 4; c++) any |= rd_log[c] | wr_log[c];
    total++; if (resp_cyc != 1 || resp_e !== 1'b1 || resp_d !== '0) begin bad++; $display("FAIL range_fill got cyc=%0d err=%b exp cyc=1 err=1", resp_cyc, resp_e); end
    total++; if (any !== 1'b0) begin bad++; $display("FAIL range_strobes got=%b exp=0", any); end
    step();
    send(1'b1, 1'b1, 32'd1, 32'd300, 32'hF, '1);
    watch(4);
    any = 1'b0;
    for (int c = 1; c <= 4; c++) any |= rd_log[c] | wr_log[c];
    total++; if (resp_cyc != 1 || resp_e !== 1'b1 || any !== 1'b0) begin bad++; $display("FAIL range_wb got cyc=%0d err=%b strobes=%b exp 1,1,0", resp_cyc, resp_e, any); end
    step();
    send(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, '0);
    watch(3);
    total++; if (resp_cyc != 1 || resp_e !== 1'b0 || resp_d !== '0) begin bad++; $display("FAIL noop got cyc=%0d err=%b exp cyc=1 err=0", resp_cyc, resp_e); end
    step();
  endtask

  task automatic test_timeout();
    mute = 1'b1;
    send(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, '0);
    watch(12);
    total++; if (resp_cyc != 10) begin bad++; $display("FAIL to_latency got=%0d exp=10", resp_cyc); end
    total++; if (resp_e !== 1'b1 || resp_d !== '0) begin bad++; $display("FAIL to_resp got err=%b data=%h exp err=1 data=0", resp_e, resp_d); end
    // replay cycles 10-11 precisely for the stray-valid and re-accept checks
    mute = 1'b0;
    send(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, '0);
    mute = 1'b1;
    for (int c = 1; c < 10; c++) step();
    mute = 1'b0;
    step();
    stray = 1'b1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL to_reaccept got ready=%b resp=%b exp 1,0", req_ready, resp_valid); end
    send(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, '0);
    stray = 1'b0;
    watch(6);
    total++; if (resp_cyc != 4 || resp_d !== PAT_A5 || resp_e !== 1'b0) begin bad++; $display("FAIL to_after got cyc=%0d err=%b exp cyc=4 err=0 A5 line", resp_cyc, resp_e); end
    step();
  endtask

  task automatic test_reset_mid_read();
    int nresp;
    send(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, '0);
    step();
    rst_n = 1'b0;
    step();
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_state got ready=%b resp=%b exp 1,0", req_ready, resp_valid); end
    total++; if ({mem_read, mem_write} !== 2'b00 || mem_a !== 32'd0) begin bad++; $display("FAIL rst_mid_mem got rd=%b wr=%b a=%h exp 0", mem_read, mem_write, mem_a); end
    rst_n = 1'b1;
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      nresp += int'(resp_valid);
      step();
    end
    total++; if (nresp != 0 || req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_late got resp=%0d ready=%b exp 0,1", nresp, req_ready); end
  endtask

  task automatic test_back_to_back();
    int r1, r2, acc, consec;
    logic prev;
    logic [255:0] d1, d2;
    r1 = -1; r2 = -1; acc = -1; consec = 0; prev = 1'b0; d1 = '0; d2 = '0;
    send(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, '0);
    req_valid = 1'b1; req_addr = 32'd9;
    for (int c = 1; c <= 12; c++) begin
      if (resp_valid) begin
        if (r1 < 0) begin r1 = c; d1 = resp_data; end
        else if (r2 < 0) begin r2 = c; d2 = resp_data; end
      end
      if (mem_read && prev) consec++;
      prev = mem_read;
      if (req_valid && req_ready && acc < 0) acc = c;
      step();
      if (acc == c) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total++; if (r1 != 4 || d1 !== PAT_A5) begin bad++; $display("FAIL b2b_first got cyc=%0d data=%h exp 4", r1, d1); end
    total++; if (acc != 5) begin bad++; $display("FAIL b2b_accept got=%0d exp=5", acc); end
    total++; if (r2 != 9 || d2 !== PAT_9) begin bad++; $display("FAIL b2b_second got cyc=%0d data=%h exp 9", r2, d2); end
    total++; if (consec != 0) begin bad++; $display("FAIL b2b_consec_read got=%0d exp=0", consec); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_fill = 1'b0; req_wb = 1'b0;
    req_addr = '0; req_wb_addr = '0; req_wb_be = '0; req_wb_data = '0;
    step();
    preload(8'd3, PAT_A5);
    preload(8'd5, '0);
    preload(8'd9, PAT_9);
    test_reset();
    test_fill_only();
    test_wb_fill();
    test_wb_only();
    test_range_and_noop();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_fill_ctrl.md
Name: mem_fill_ctrl

Overview:
- Cache-side initiator for the 256-bit line main memory.
- Accepts one line request at a time from the cache miss logic. Each request can carry an optional dirty-victim writeback, an optional line fill, or both.
- Sequences the memory's address-before-write and pulsed-read timing, then returns the fill line to the cache with a one-cycle response pulse.
- Guards against out-of-range addresses and a memory that never returns valid.

Parameters:
- ENTRIES, 256, number of memory lines; valid line addresses are 0..ENTRIES-1.
- TIMEOUT, 8, maximum number of RD_WAIT cycles spent waiting for mem_valid before an error response.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_fill  in  1  fetch line at req_addr
- req_addr  in  32  fill line address
- req_wb  in  1  write victim line before the fill
- req_wb_addr  in  32  victim line address
- req_wb_be  in  32  victim byte enables
- req_wb_data  in  256  victim line data
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  error qualifier, valid with resp_valid
- resp_data  out  256  fill line
- mem_a  out  32  memory line address
- mem_be  out  32  memory byte enables
- mem_wd  out  256  memory write data
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_rd  in  256  memory read data
- mem_valid  in  1  memory read data valid

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst_n is synchronous and active-low.
  - Reset forces state IDLE and clears all outputs to 0, except req_ready, which is 1 in IDLE.
  - Reset mid-operation abandons the operation. A late mem_valid arriving after reset is ignored because IDLE never samples memory.
- Request acceptance:
  - req_ready = (state==IDLE).
  - A request is accepted on any edge where req_valid & req_ready; request fields are latched at that edge.
  - A request with req_wb=0 and req_fill=0 goes straight to RESP with resp_err=0 and resp_data=0.
- Range check at acceptance: if (req_wb and req_wb_addr>=ENTRIES) or (req_fill and req_addr>=ENTRIES):
  - go directly to RESP with resp_err=1 and resp_data=0;
  - no memory strobes are issued.
- State machine: IDLE, WB_SETUP, WB_COMMIT, RD_ISSUE, RD_WAIT, RESP.
  - WB_SETUP: mem_a=wb_addr, mem_write=0. This gives the memory one cycle to register the address.
  - WB_COMMIT: mem_a=wb_addr, mem_write=1, mem_be=wb_be, mem_wd=wb_data. Next state is RD_ISSUE if fill is requested, else RESP.
  - RD_ISSUE: mem_a=fill addr, mem_read=1 for exactly one cycle. A write committed in the preceding cycle is visible to this read.
  - RD_WAIT: mem_read=0 and the wait counter increments each cycle.
    - On mem_valid: capture mem_rd into resp_data and go to RESP.
    - If the counter reaches TIMEOUT without mem_valid: resp_err=1, resp_data=0, go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. There is no backpressure on the response; the cache must accept it.
- Strobe rules:
  - mem_read is never high in two consecutive cycles (the memory drops back-to-back reads).
  - In every state other than those listed above, mem_a, mem_be, mem_wd, mem_write and mem_read are all 0.
- Spurious inputs: mem_valid outside RD_WAIT is ignored.
- Latency, counted from the accept edge (cycle 0); nominal memory read latency is 2:
  - fill only: resp_valid in cycle 4;
  - wb+fill: resp_valid in cycle 6;
  - wb only: resp_valid in cycle 3;
  - range error: resp_valid in cycle 1;
  - timeout: resp_valid in cycle 2+TIMEOUT.
- Counter: wait counter width is clog2(TIMEOUT+1); it clears on entry to RD_ISSUE.
- Throughput: the next request can be accepted in the cycle after RESP.

Decomposition:
- Shared package mem_fill_pkg holds:
  - LINE_W=256, BE_W=32, ADDR_W=32;
  - the state enum (IDLE..RESP).
- No sub-module. The FSM, latch registers and wait counter form a single module of about 200 lines.

Test Plan:
- Fill only: req_fill=1, addr=3, memory line 3 preloaded with 0xA5 repeated → mem_read pulses one cycle with mem_a=3; resp_valid in cycle 4, resp_data = the 0xA5 pattern, resp_err=0.
- WB+fill same line: wb_addr=5, be=0x0000000F, wd low word=0xDEADBEEF; fill addr=5, line preloaded to 0 → mem_write high only in cycle 2 with mem_a=5 held in cycles 1-2; resp_valid in cycle 6, resp_data[31:0]=0xDEADBEEF, rest 0.
- Range error: req_fill=1, addr=256 → resp_valid=1 and resp_err=1 in cycle 1; mem_read and mem_write never asserted.
- Timeout: memory stub holds mem_valid=0 → resp_valid in cycle 10 with resp_err=1 and resp_data=0; a stray mem_valid in cycle 11 is ignored, and a new request is accepted in cycle 11.
- Reset mid-read: rst_n low in cycle 2 of a fill → next cycle req_ready=1, all mem_* outputs 0, no resp_valid; the returning mem_valid is ignored.
- Back-to-back: two fill requests, the second held on req_valid → accepted in the cycle after the first RESP; mem_read is never high in consecutive cycles.
